// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing, derived totals, 3-3-2 pixel fields and the raster flag bundle
package vga_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int RGB_R_MSB = 7;
    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_MSB = 4;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_MSB = 1;
    localparam int RGB_B_LSB = 0;
    // raster flags that travel alongside a pixel while its read is in flight
    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic org;
    } vflags_t;
    localparam vflags_t FLAGS_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, org: 1'b0};
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: framebuffer read port between the scanout engine and the pixel store
interface fb_scanout_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd;
    logic [7:0]        fb_data;
    modport master (output fb_addr, fb_rd, input fb_data);
    modport slave  (input fb_addr, fb_rd, output fb_data);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster h/v counters, visible window, raw active-low syncs and frame origin flag
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW = cnt_w(HT),
    localparam int VW = cnt_w(VT)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          visible_o,
    output logic          hsync_raw_o,
    output logic          vsync_raw_o,
    output logic          origin_o,
    output logic          line_end_o,
    output logic          frame_end_o
);
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_end, v_end;

    // next raster position: h wraps every line, v advances on h wrap and wraps per frame
    always_comb begin
        h_end = h_q == HW'(HT - 1);
        v_end = v_q == VW'(VT - 1);
        h_d   = h_end ? '0 : h_q + 1'b1;
        v_d   = !h_end ? v_q : (v_end ? '0 : v_q + 1'b1);
    end

    // raster position state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o         = h_q;
    assign v_o         = v_q;
    assign visible_o   = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    assign hsync_raw_o = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_raw_o = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign origin_o    = (h_q == '0) && (v_q == '0);
    assign line_end_o  = h_end;
    assign frame_end_o = h_end && v_end;
endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: raster scan of a power-of-two downscaled framebuffer out to an RGB 3-3-2 DAC
module fb_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int RD_LAT      = 1
) (
    input  logic       clk,
    input  logic       rst,
    fb_scanout_if.master fb,
    output logic [7:0] rgb,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);
    localparam int HW        = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW        = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int LINE_STEP = H_ACTIVE >> SCALE_SHIFT;
    localparam logic [VW-1:0] BLK_MASK = VW'((1 << SCALE_SHIFT) - 1);

    logic [HW-1:0]     h;
    logic [VW-1:0]     v, v_next;
    logic              visible, hs_raw, vs_raw, origin, line_end, frame_end;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic              rd_q;
    vflags_t           cur;
    vflags_t [RD_LAT:0] pipe_q;
    logic [7:0]        rgb_q;
    logic              hsync_q, vsync_q, fs_q;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst(rst), .h_o(h), .v_o(v), .visible_o(visible),
        .hsync_raw_o(hs_raw), .vsync_raw_o(vs_raw), .origin_o(origin),
        .line_end_o(line_end), .frame_end_o(frame_end)
    );

    // line base steps one stored row each time the next display line starts a new block row
    always_comb begin
        v_next = v + 1'b1;
        base_d = frame_end ? '0
               : (line_end && ((v_next & BLK_MASK) == '0)) ? base_q + ADDR_W'(LINE_STEP)
               : base_q;
        addr_d = visible ? base_q + ADDR_W'(h >> SCALE_SHIFT) : addr_q;
        cur    = '{vis: visible, hs: hs_raw, vs: vs_raw, org: origin};
    end

    // read request stage: address and strobe issued one clock after the counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            addr_q <= '0;
            rd_q   <= 1'b0;
        end else begin
            base_q <= base_d;
            addr_q <= addr_d;
            rd_q   <= visible;
        end
    end

    // flag pipeline: stage 0 rides with the request, the last stage lines up with read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= {(RD_LAT + 1){FLAGS_IDLE}};
        else     pipe_q <= {pipe_q[RD_LAT-1:0], cur};
    end

    // output register: blank the pixel outside the visible window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q   <= 8'h00;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            rgb_q   <= pipe_q[RD_LAT].vis ? fb.fb_data : 8'h00;
            hsync_q <= pipe_q[RD_LAT].hs;
            vsync_q <= pipe_q[RD_LAT].vs;
            fs_q    <= pipe_q[RD_LAT].org;
        end
    end

    assign fb.fb_addr  = addr_q;
    assign fb.fb_rd    = rd_q;
    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed checks of raster timing, address mapping, blanking and latency
module tb_fb_scanout;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ff_mode = 1'b0;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // edges since reset release; edge k is the k-th rising edge with rst low
    always @(posedge clk) edge_n <= rst ? 0 : edge_n + 1;

    fb_scanout_if #(.ADDR_W(15)) ia ();
    fb_scanout_if #(.ADDR_W(15)) ib ();
    fb_scanout_if #(.ADDR_W(15)) ic ();

    logic [7:0] rgb_a, rgb_b, rgb_c;
    logic       hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, fs_a, fs_b, fs_c;

    fb_scanout #(.RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .fb(ia.master),
        .rgb(rgb_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    fb_scanout #(.RD_LAT(3)) u_b (
        .clk(clk), .rst(rst), .fb(ib.master),
        .rgb(rgb_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    fb_scanout #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SCALE_SHIFT(2), .ADDR_W(15), .RD_LAT(1)
    ) u_c (
        .clk(clk), .rst(rst), .fb(ic.master),
        .rgb(rgb_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c)
    );

    logic [7:0] mem_a, mem_c;
    logic [7:0] mem_b [3];

    always @(posedge clk) begin
        mem_a    <= ff_mode ? 8'hFF : ia.fb_addr[7:0];
        mem_c    <= ff_mode ? 8'hFF : ic.fb_addr[7:0];
        mem_b[0] <= ff_mode ? 8'hFF : ib.fb_addr[7:0];
        mem_b[1] <= mem_b[0];
        mem_b[2] <= mem_b[1];
    end

    assign ia.fb_data = mem_a;
    assign ib.fb_data = mem_b[2];
    assign ic.fb_data = mem_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic at_edge(input int k);
        while (edge_n < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(rgb_a), 0);
        chk("rst_hs", 32'(hs_a), 1);
        chk("rst_vs", 32'(vs_a), 1);
        chk("rst_fs", 32'(fs_a), 0);
        chk("rst_rd", 32'(ia.fb_rd), 0);
        chk("rst_addr", 32'(ia.fb_addr), 0);
        chk("rst_b_hs", 32'(hs_b), 1);
        rst = 1'b0;
        at_edge(1);
        chk("a_addr00", 32'(ia.fb_addr), 0);
        chk("a_rd00", 32'(ia.fb_rd), 1);
        at_edge(3);
        chk("a_fs_first", 32'(fs_a), 1);
        chk("a_rgb00", 32'(rgb_a), 0);
        chk("a_hs00", 32'(hs_a), 1);
        chk("a_vs00", 32'(vs_a), 1);
        chk("c_fs_first", 32'(fs_c), 1);
        at_edge(4);
        chk("a_fs_pulse", 32'(fs_a), 0);
        chk("b_fs_early", 32'(fs_b), 0);
        at_edge(5);
        chk("b_fs_first", 32'(fs_b), 1);
        chk("b_rgb00", 32'(rgb_b), 0);
        at_edge(6);
        chk("a_rgb30", 32'(rgb_a), 0);
        at_edge(7);
        chk("a_rgb40", 32'(rgb_a), 1);
        chk("a_addr60", 32'(ia.fb_addr), 1);
        chk("c_rgb40", 32'(rgb_c), 1);
        at_edge(9);
        chk("b_rgb40", 32'(rgb_b), 1);
        at_edge(32);
        chk("c_rd31", 32'(ic.fb_rd), 1);
        at_edge(33);
        chk("c_rd32", 32'(ic.fb_rd), 0);
        at_edge(35);
        chk("c_hblank", 32'(rgb_c), 0);
        at_edge(38);
        chk("c_hs35", 32'(hs_c), 1);
        at_edge(39);
        chk("c_hs36", 32'(hs_c), 0);
        at_edge(46);
        chk("c_hs43", 32'(hs_c), 0);
        at_edge(47);
        chk("c_hs44", 32'(hs_c), 1);
        at_edge(195);
        chk("c_rgb04", 32'(rgb_c), 8);
        at_edge(640);
        chk("a_rd639", 32'(ia.fb_rd), 1);
        at_edge(641);
        chk("a_rd640", 32'(ia.fb_rd), 0);
        at_edge(642);
        chk("a_rgb639", 32'(rgb_a), 159);
        at_edge(643);
        chk("a_hblank", 32'(rgb_a), 0);
        at_edge(658);
        chk("a_hs655", 32'(hs_a), 1);
        at_edge(659);
        chk("a_hs656", 32'(hs_a), 0);
        at_edge(660);
        chk("b_hs655", 32'(hs_b), 1);
        at_edge(661);
        chk("b_hs656", 32'(hs_b), 0);
        at_edge(754);
        chk("a_hs751", 32'(hs_a), 0);
        chk("c_rgb_last", 32'(rgb_c), 31);
        at_edge(755);
        chk("a_hs752", 32'(hs_a), 1);
        at_edge(769);
        chk("c_rd_vblank", 32'(ic.fb_rd), 0);
        at_edge(771);
        chk("c_vblank", 32'(rgb_c), 0);
        at_edge(804);
        chk("a_rgb11", 32'(rgb_a), 0);
        at_edge(866);
        chk("c_vs_l17", 32'(vs_c), 1);
        at_edge(867);
        chk("c_vs_l18", 32'(vs_c), 0);
        at_edge(962);
        chk("c_vs_l19e", 32'(vs_c), 0);
        at_edge(963);
        chk("c_vs_l20", 32'(vs_c), 1);
        at_edge(1058);
        chk("c_fs_end", 32'(fs_c), 0);
        at_edge(1059);
        chk("c_fs_next", 32'(fs_c), 1);
        chk("c_rgb00_f2", 32'(rgb_c), 0);
        at_edge(1064);
        chk("c_rgb50_f2", 32'(rgb_c), 1);
        at_edge(1255);
        chk("c_rgb44_f2", 32'(rgb_c), 9);
        at_edge(1458);
        chk("a_hs_l1_655", 32'(hs_a), 1);
        at_edge(1459);
        chk("a_hs_l1_656", 32'(hs_a), 0);
        at_edge(2403);
        chk("a_rgb03", 32'(rgb_a), 0);
        at_edge(3203);
        chk("a_rgb04", 32'(rgb_a), 160);
        at_edge(3205);
        chk("b_rgb04", 32'(rgb_b), 160);
        at_edge(3211);
        chk("a_rgb84", 32'(rgb_a), 162);
        at_edge(3842);
        chk("a_rgb639_4", 32'(rgb_a), 63);
        at_edge(3844);
        chk("b_rgb639_4", 32'(rgb_b), 63);
        rst = 1'b1;
        #1;
        chk("mid_rgb", 32'(rgb_a), 0);
        chk("mid_hs", 32'(hs_a), 1);
        chk("mid_vs", 32'(vs_a), 1);
        chk("mid_fs", 32'(fs_a), 0);
        chk("mid_rd", 32'(ia.fb_rd), 0);
        chk("mid_addr", 32'(ia.fb_addr), 0);
        chk("mid_b_rgb", 32'(rgb_b), 0);
        ff_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        at_edge(1);
        chk("ff_addr00", 32'(ia.fb_addr), 0);
        at_edge(3);
        chk("ff_fs", 32'(fs_a), 1);
        chk("ff_rgb00", 32'(rgb_a), 255);
        at_edge(5);
        chk("ff_b_rgb00", 32'(rgb_b), 255);
        at_edge(642);
        chk("ff_rgb639", 32'(rgb_a), 255);
        at_edge(643);
        chk("ff_rgb640", 32'(rgb_a), 0);
        at_edge(644);
        chk("ff_b_rgb639", 32'(rgb_b), 255);
        at_edge(645);
        chk("ff_b_rgb640", 32'(rgb_b), 0);
        at_edge(754);
        chk("ff_c_last", 32'(rgb_c), 255);
        at_edge(755);
        chk("ff_c_hblank", 32'(rgb_c), 0);
        at_edge(771);
        chk("ff_c_vblank", 32'(rgb_c), 0);
        at_edge(802);
        chk("ff_rgb799", 32'(rgb_a), 0);
        at_edge(803);
        chk("ff_rgb01", 32'(rgb_a), 255);
        at_edge(1058);
        chk("ff_c_end", 32'(rgb_c), 0);
        at_edge(1059);
        chk("ff_c_f2", 32'(rgb_c), 255);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
